// File: rtl/rtc_scan_sequencer_if.sv
// Command/response bus between the scan sequencer and the RTC engine.
// The master issues dir/func/data commands; the slave returns ready/rdata.
interface rtc_scan_sequencer_if;
    logic       cmd_valid;
    logic [7:0] cmd_dir;
    logic [7:0] cmd_func;
    logic [7:0] cmd_data;
    logic [7:0] bus_ready;
    logic [7:0] bus_rdata;

    modport master (
        output cmd_valid, cmd_dir, cmd_func, cmd_data,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_func, cmd_data,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/rtc_scan_sequencer.sv
// RTC command sequencer: one init write, periodic six-register time scan,
// and user single-register writes, one engine transaction at a time.
module rtc_scan_sequencer #(
    parameter int         REFRESH_CYCLES = 1000000,
    parameter int         TIMEOUT        = 255,
    parameter logic [7:0] INIT_ADDR      = 8'h02,
    parameter logic [7:0] INIT_DATA      = 8'h10
) (
    input  logic                 clock,
    input  logic                 reset,
    rtc_scan_sequencer_if.master bus,
    input  logic                 wr_req,
    input  logic [7:0]           wr_addr,
    input  logic [7:0]           wr_data,
    output logic                 wr_ack,
    input  logic                 err_clr,
    output logic [7:0]           sec,
    output logic [7:0]           min,
    output logic [7:0]           hour,
    output logic [7:0]           day,
    output logic [7:0]           month,
    output logic [7:0]           year,
    output logic                 snapshot_valid,
    output logic                 busy,
    output logic                 bus_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_CLR  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CAPTURE   = 3'd4;

    localparam logic [1:0] K_INIT = 2'd0;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_RD   = 2'd2;

    localparam int TW = $clog2(TIMEOUT + 1) + 1;

    logic [2:0]    state;
    logic [1:0]    kind;
    logic [31:0]   timer;
    logic [2:0]    idx;
    logic          scan_pending;
    logic          init_pending;
    logic [TW-1:0] tmo;
    logic [7:0]    rd_q;
    logic [7:0]    shadow [6];
    logic          cmd_valid_q;
    logic [7:0]    dir_q;
    logic [7:0]    func_q;
    logic [7:0]    data_q;

    logic          tick;
    logic          waiting;
    logic [TW-1:0] tmo_inc;
    logic          expired;
    logic          scan_start;

    assign tick    = (timer == 32'(REFRESH_CYCLES - 1));
    assign waiting = (state == S_WAIT_CLR) || (state == S_WAIT_DONE);
    assign tmo_inc = tmo + 1'b1;
    assign expired = waiting && (tmo_inc >= TW'(TIMEOUT));

    // A fresh scan starts only when nothing of higher priority is waiting.
    assign scan_start = (state == S_IDLE) && !init_pending && !wr_req &&
                        (idx == 3'd0) && scan_pending;

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_dir   = dir_q;
    assign bus.cmd_func  = func_q;
    assign bus.cmd_data  = data_q;

    assign sec   = shadow[0];
    assign min   = shadow[1];
    assign hour  = shadow[2];
    assign day   = shadow[3];
    assign month = shadow[4];
    assign year  = shadow[5];

    assign busy = (state != S_IDLE);

    assign wr_ack = (kind == K_WR) &&
                    ((state == S_CAPTURE) || expired);

    assign snapshot_valid = (state == S_CAPTURE) &&
                            (kind == K_RD) && (idx == 3'd5);

    // Free-running refresh timer that wraps every REFRESH_CYCLES.
    always_ff @(posedge clock) begin
        if (reset || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // Scan request; extra ticks merge into the one already pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_pending <= 1'b0;
        end else if (scan_start) begin
            scan_pending <= 1'b0;
        end else if (tick) begin
            scan_pending <= 1'b1;
        end
    end

    // Transaction FSM, command registers, shadows and error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            kind         <= K_INIT;
            idx          <= 3'd0;
            init_pending <= 1'b1;
            tmo          <= '0;
            rd_q         <= 8'h00;
            cmd_valid_q  <= 1'b0;
            dir_q        <= 8'hFF;
            func_q       <= 8'h00;
            data_q       <= 8'h00;
            bus_err      <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                shadow[i] <= 8'h00;
            end
        end else begin
            cmd_valid_q <= 1'b0;
            if (err_clr) begin
                bus_err <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (init_pending) begin
                        kind        <= K_INIT;
                        dir_q       <= INIT_ADDR;
                        func_q      <= 8'h02;
                        data_q      <= INIT_DATA;
                        cmd_valid_q <= 1'b1;
                        state       <= S_ISSUE;
                    end else if (wr_req) begin
                        kind        <= K_WR;
                        dir_q       <= wr_addr;
                        func_q      <= 8'h02;
                        data_q      <= wr_data;
                        cmd_valid_q <= 1'b1;
                        state       <= S_ISSUE;
                    end else if (idx != 3'd0 || scan_pending) begin
                        kind        <= K_RD;
                        dir_q       <= 8'h21 + {5'b0, idx};
                        func_q      <= 8'h01;
                        data_q      <= 8'h00;
                        cmd_valid_q <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo   <= '0;
                    state <= S_WAIT_CLR;
                end
                S_WAIT_CLR: begin
                    tmo <= tmo_inc;
                    if (!expired && bus.bus_ready == 8'h00) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    tmo <= tmo_inc;
                    if (!expired && bus.bus_ready == 8'hFF) begin
                        rd_q  <= bus.bus_rdata;
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (kind == K_RD) begin
                        shadow[idx] <= rd_q;
                        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                    end
                    if (kind == K_INIT) begin
                        init_pending <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // An abandoned transaction drops the scan and flags the error.
            if (expired) begin
                bus_err      <= 1'b1;
                idx          <= 3'd0;
                init_pending <= 1'b0;
                state        <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_rtc_scan_sequencer.sv
// Randomized bench for rtc_scan_sequencer with a transaction-level model
// of the scheduling rules and a simple delay-programmable engine.
module tb_rtc_scan_sequencer;

    localparam int R   = 100;
    localparam int TMO = 255;
    localparam int K_INIT = 1;
    localparam int K_WR   = 2;
    localparam int K_RD   = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack;
    logic       err_clr = 1'b0;
    logic [7:0] sec, min, hour, day, month, year;
    logic       snapshot_valid, busy, bus_err;

    rtc_scan_sequencer_if bus ();

    always #5 clock = ~clock;

    rtc_scan_sequencer #(
        .REFRESH_CYCLES(R),
        .TIMEOUT(TMO),
        .INIT_ADDR(8'h02),
        .INIT_DATA(8'h10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack(wr_ack),
        .err_clr(err_clr),
        .sec(sec),
        .min(min),
        .hour(hour),
        .day(day),
        .month(month),
        .year(year),
        .snapshot_valid(snapshot_valid),
        .busy(busy),
        .bus_err(bus_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rel0     = 0;
    bit in_model = 0;

    int         eng_a_at = -1;
    int         eng_b_at = -1;
    logic [7:0] eng_rd = 8'h00;
    bit         first_txn = 0;
    bit         slow_next = 0;
    bit         stuck_next = 0;
    bit         stuck_now = 0;
    int         slow_c = 0;

    bit         m_init, m_scan;
    int         m_idx;
    int         cur_kind, cur_idx, cur_e;
    bit         cur_abort;
    logic [7:0] cur_rd;
    int         idle_from;
    bit         exp_err, abort_prev;
    int         sh_chk_at, sh_chk_i;
    logic [7:0] exp_sh [6];
    int         snaps = 0;
    bit         saw_abort = 0;

    bit wr_en = 0;
    bit ec_en = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    function automatic logic [7:0] obs_sh(input int i);
        case (i)
            0: return sec;
            1: return min;
            2: return hour;
            3: return day;
            4: return month;
            default: return year;
        endcase
    endfunction

    task automatic model_init();
        m_init = 1; m_scan = 0; m_idx = 0;
        cur_kind = 0; cur_idx = 0; cur_e = 0; cur_abort = 0;
        cur_rd = 8'h00; idle_from = rel0;
        exp_err = 0; abort_prev = 0; sh_chk_at = -1; sh_chk_i = 0;
        for (int i = 0; i < 6; i++) exp_sh[i] = 8'h00;
    endtask

    task automatic chk_reset();
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_cmd_dir", bus.cmd_dir, 8'hFF);
        check("rst_cmd_func", bus.cmd_func, 8'h00);
        check("rst_cmd_data", bus.cmd_data, 8'h00);
        for (int i = 0; i < 6; i++) check("rst_shadow", obs_sh(i), 8'h00);
        check("rst_snapshot", snapshot_valid, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_bus_err", bus_err, 0);
    endtask

    task automatic engine_sched();
        int a, b;
        if (!bus.cmd_valid) return;
        stuck_now = 0;
        if (first_txn) begin
            a = 2; b = 30;
        end else if (slow_next) begin
            a = 2; b = 60; slow_c = cyc; slow_next = 0;
        end else begin
            a = $urandom_range(1, 4);
            b = a + $urandom_range(2, 40);
        end
        first_txn = 0;
        if (stuck_next && bus.cmd_func == 8'h01) begin
            stuck_next = 0; stuck_now = 1;
            eng_a_at = -1; eng_b_at = -1;
        end else begin
            eng_a_at = cyc + a; eng_b_at = cyc + b;
        end
        eng_rd = (bus.cmd_func == 8'h01) ? bus.cmd_dir + 8'h30
                                          : 8'($urandom);
    endtask

    task automatic model_step();
        bit exp_cmd, pend_b, exp_ack, exp_snap, exp_busy;
        int pk;
        logic [7:0] pa, pf, pd;
        exp_ack = 0; exp_snap = 0;
        if (abort_prev) exp_err = 1;
        else if (err_clr) exp_err = 0;
        abort_prev = 0;
        if (bus_err !== exp_err || cyc % 50 == 0)
            check("bus_err", bus_err, exp_err);
        pend_b = m_scan;
        exp_cmd = (cur_kind == 0) && (idle_from <= cyc - 1) &&
                  (m_init || wr_req || m_idx != 0 || m_scan);
        if (exp_cmd || bus.cmd_valid)
            check("cmd_valid", bus.cmd_valid, exp_cmd);
        if (exp_cmd) begin
            if (m_init) begin
                pk = K_INIT; pa = 8'h02; pf = 8'h02; pd = 8'h10;
            end else if (wr_req) begin
                pk = K_WR; pa = wr_addr; pf = 8'h02; pd = wr_data;
            end else begin
                pk = K_RD; pa = 8'h21 + 8'(m_idx); pf = 8'h01; pd = 8'h00;
                if (m_idx == 0) m_scan = 0;
            end
            check("cmd_dir", bus.cmd_dir, pa);
            check("cmd_func", bus.cmd_func, pf);
            if (pk != K_RD) check("cmd_data", bus.cmd_data, pd);
            cur_kind = pk; cur_idx = m_idx;
            cur_rd = pa + 8'h30;
            cur_abort = stuck_now;
            cur_e = stuck_now ? cyc + TMO : eng_b_at + 1;
        end
        if (((cyc - 1 - rel0) % R == R - 1) && !pend_b) m_scan = 1;
        exp_busy = (cur_kind != 0);
        if (busy !== exp_busy || cyc % 50 == 0)
            check("busy", busy, exp_busy);
        if (cur_kind != 0 && cyc == cur_e) begin
            exp_ack = (cur_kind == K_WR);
            if (cur_abort) begin
                abort_prev = 1; m_idx = 0; m_init = 0; saw_abort = 1;
            end else if (cur_kind == K_INIT) begin
                m_init = 0;
            end else if (cur_kind == K_RD) begin
                exp_sh[cur_idx] = cur_rd;
                sh_chk_at = cyc + 1; sh_chk_i = cur_idx;
                exp_snap = (cur_idx == 5);
                m_idx = (cur_idx == 5) ? 0 : cur_idx + 1;
            end
            idle_from = cyc + 1;
            cur_kind = 0;
        end
        if (exp_ack || wr_ack) check("wr_ack", wr_ack, exp_ack);
        if (exp_snap || snapshot_valid)
            check("snapshot_valid", snapshot_valid, exp_snap);
        if (snapshot_valid) snaps++;
        if (cyc == sh_chk_at)
            check("shadow", obs_sh(sh_chk_i), exp_sh[sh_chk_i]);
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        engine_sched();
        if (in_model) model_step();
        if (cyc == eng_a_at) bus.bus_ready = 8'h00;
        if (cyc == eng_b_at) begin
            bus.bus_ready = 8'hFF;
            bus.bus_rdata = eng_rd;
        end
        if (wr_ack) begin
            wr_req = 0;
        end else if (wr_en && !wr_req && $urandom_range(0, 59) == 0) begin
            wr_req = 1;
            wr_addr = 8'($urandom);
            wr_data = 8'($urandom);
        end
        if (ec_en) err_clr = ($urandom_range(0, 99) == 0);
    endtask

    task automatic release_reset();
        reset = 0;
        rel0 = cyc;
        model_init();
        first_txn = 1;
        in_model = 1;
    endtask

    task automatic drain_writes();
        wr_en = 0;
        for (int i = 0; i < 2000 && wr_req; i++) step();
        check("wr_drain", wr_req, 0);
    endtask

    initial begin
        bus.bus_ready = 8'hFF;
        bus.bus_rdata = 8'h00;
        repeat (3) step();
        chk_reset();
        release_reset();

        wr_en = 1; ec_en = 1;
        repeat (3000) step();
        ec_en = 0; err_clr = 0;
        drain_writes();

        stuck_next = 1;
        for (int i = 0; i < 2000 && !saw_abort; i++) step();
        check("timeout_seen", saw_abort, 1);
        repeat (2) step();
        check("bus_err_set", bus_err, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        step();
        check("bus_err_cleared", bus_err, 0);

        wr_en = 1;
        repeat (300) step();
        drain_writes();
        slow_next = 1;
        slow_c = 0;
        for (int i = 0; i < 2000 && slow_c == 0; i++) step();
        check("slow_txn_issued", slow_c != 0, 1);
        repeat (5) step();
        reset = 1;
        in_model = 0;
        step();
        chk_reset();
        repeat (70) step();
        release_reset();
        wr_en = 1; ec_en = 1;
        repeat (1500) step();

        check("snapshots_seen", snaps > 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
